// File: rtl/sd_read_arbiter_if.sv
// sd_read_arbiter_if: requester and SD-controller signals around the read arbiter
interface sd_read_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_done;
  logic [31:0]               rd_data;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      init_done;
  logic [ADDR_W-1:0]         sd_addr;
  logic                      sd_read_start;
  logic                      sd_read_done;
  logic [31:0]               sd_response_data;
  logic                      rd_error;
  modport master (
    input  req, req_addr, init_done, sd_read_done, sd_response_data,
    output req_done, rd_data, grant_id, busy, sd_addr, sd_read_start, rd_error
  );
  modport slave (
    output req, req_addr, init_done, sd_read_done, sd_response_data,
    input  req_done, rd_data, grant_id, busy, sd_addr, sd_read_start, rd_error
  );
endinterface

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin sharing of the SD single-block read path; SD_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog
module sd_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic reset,
  sd_read_arbiter_if.master bus
);
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sd_read_arbiter: illegal parameters");
  end
  typedef enum logic [2:0] {WAIT_INIT, ARB, ISSUE, WAIT_DONE, RELEASE} state_t;
  state_t              state, state_d;
  logic [1:0]          rr_ptr, rr_d, grant_q, grant_d, win;
  logic                hit;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d, start_q, start_d;
`ifdef SD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif
  // descending scan so the nearest set bit after rr_ptr wins
  always_comb begin
    win = rr_ptr;
    hit = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win = 2'((int'(rr_ptr) + k) % NUM_REQ);
        hit = 1'b1;
      end
  end
  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = '0;
    busy_d  = busy_q;
    start_d = start_q;
`ifdef SD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    if (state != WAIT_INIT && !bus.init_done) begin
      state_d = WAIT_INIT;
      busy_d  = 1'b0;
      start_d = 1'b0;
    end else begin
      case (state)
        WAIT_INIT: state_d = bus.init_done ? ARB : WAIT_INIT;
        ARB: if (hit) begin
          state_d = ISSUE;
          rr_d    = win;
          grant_d = win;
          addr_d  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
          busy_d  = 1'b1;
        end
        ISSUE: begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
`ifdef SD_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
        WAIT_DONE: if (bus.sd_read_done) begin
          data_d  = bus.sd_response_data;
          done_d  = NUM_REQ'(1) << grant_q;
          start_d = 1'b0;
          state_d = RELEASE;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (cnt_q == LAST) begin
          done_d  = NUM_REQ'(1) << grant_q;
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = RELEASE;
        end else cnt_d = cnt_q + 1'b1;
`endif
        RELEASE: if (!bus.sd_read_done) begin
          busy_d  = 1'b0;
          state_d = ARB;
        end
        default: state_d = WAIT_INIT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_INIT;
      rr_ptr  <= 2'(NUM_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end
`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.rd_error = err_q;
`else
  assign bus.rd_error = 1'b0;
`endif
  assign bus.req_done      = done_q;
  assign bus.rd_data       = data_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = busy_q;
  assign bus.sd_addr       = addr_q;
  assign bus.sd_read_start = start_q;
endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: scoreboard bench with SD controller model, requester models and round-robin reference
module tb_sd_read_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int TO = 64;
  typedef struct { int id; logic [31:0] data; logic err; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sd_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();
  sd_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0, ndone = 0, hold_seen = 0;
  exp_t sb[$];
  int gseq[$];
  logic [AW-1:0] gaddr[$];
  logic [N-1:0] en_mask = '0, hist0, hist1, prev_done = '0;
  logic [AW-1:0] fix_addr [N];
  bit rand_mode = 0, ctl_rand = 0, ctl_mute = 0;
  int ctl_lat = 20, ctl_hold = 0;
  logic [31:0] ctl_data = 32'hDEADBEEF, last_data = '0, d_next;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // requesters: drop on own req_done, re-raise when enabled
  always @(negedge clk) begin
    if (reset) begin
      bus.req = '0;
      bus.req_addr = '0;
    end else for (int i = 0; i < N; i++) begin
      if (bus.req[i] && bus.req_done[i]) bus.req[i] = 1'b0;
      else if (!bus.req[i] && en_mask[i] && (!rand_mode || $urandom_range(0, 3) == 0)) begin
        bus.req_addr[i*AW +: AW] = rand_mode ? $urandom : fix_addr[i];
        bus.req[i] = 1'b1;
      end
    end
  end
  always @(posedge clk) begin
    hist1 <= hist0;
    hist0 <= bus.req;
  end
  // SD controller model plus round-robin reference
  int cs = 0, cnt = 0, hi = 0, last = N - 1, cur_id = -1;
  logic [AW-1:0] cur_addr;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      cs = 0; last = N - 1; prev_start = 1'b0;
      bus.sd_read_done = 1'b0;
      bus.sd_response_data = '0;
    end else begin
      if (bus.sd_read_start && !prev_start) begin
        chk("start_while_done", bus.sd_read_done, 0);
        chk("grant_has_req", hist1 != '0, 1);
        cur_id = -1;
        for (int k = 1; k <= N; k++)
          if (cur_id < 0 && hist1[(last + k) % N]) cur_id = (last + k) % N;
        if (cur_id >= 0) begin
          last = cur_id;
          cur_addr = bus.req_addr[cur_id*AW +: AW];
          chk("grant_id", bus.grant_id, cur_id);
          chk("sd_addr", bus.sd_addr, cur_addr);
          chk("busy_at_start", bus.busy, 1);
          gseq.push_back(cur_id);
          gaddr.push_back(bus.sd_addr);
          if (ctl_mute) sb.push_back('{cur_id, last_data, 1'b1});
        end
        cnt = ctl_lat != 0 ? ctl_lat : $urandom_range(1, 25);
        hi = 0;
        cs = 1;
      end
      case (cs)
        1: if (!bus.sd_read_start) begin
          if (ctl_mute) chk("timeout_cycles", hi, TO);
          cs = 0;
        end else begin
          hi++;
          chk("sd_addr_stable", bus.sd_addr, cur_addr);
          cnt--;
          if (!ctl_mute && cnt == 0) begin
            d_next = ctl_rand ? $urandom : ctl_data;
            bus.sd_read_done = 1'b1;
            bus.sd_response_data = d_next;
            sb.push_back('{cur_id, d_next, 1'b0});
            last_data = d_next;
            cs = 2;
          end
        end
        2: if (!bus.sd_read_start) begin
          cnt = ctl_hold >= 0 ? ctl_hold : $urandom_range(0, 3);
          if (cnt == 0) begin bus.sd_read_done = 1'b0; cs = 0; end
          else cs = 3;
        end
        3: begin
          chk("hold_start_low", bus.sd_read_start, 0);
          chk("hold_busy", bus.busy, 1);
          hold_seen++;
          cnt--;
          if (cnt == 0) begin bus.sd_read_done = 1'b0; cs = 0; end
        end
        default: ;
      endcase
      prev_start = bus.sd_read_start;
    end
  end
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req_done != '0) begin
        chk("req_done_expected", sb.size() != 0, 1);
        chk("start_low_at_done", bus.sd_read_start, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("req_done_id", bus.req_done, N'(1) << e.id);
          chk("rd_data", bus.rd_data, e.data);
          chk("rd_error", bus.rd_error, e.err);
          ndone++;
        end
      end else chk("rd_error_idle", bus.rd_error, 0);
      if (prev_done != '0) chk("req_done_width", bus.req_done, 0);
      prev_done = bus.req_done;
    end
  end
  task automatic wait_dones(input int n);
    int tgt = ndone + n;
    for (int t = 0; t < 5000 && ndone < tgt; t++) @(negedge clk);
    chk("wait_req_done", ndone >= tgt, 1);
  endtask
  task automatic wait_start();
    for (int t = 0; t < 2000 && !bus.sd_read_start; t++) @(negedge clk);
    chk("wait_start", bus.sd_read_start, 1);
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 5000 && (bus.req != '0 || bus.busy || bus.sd_read_done); t++) @(negedge clk);
    chk("wait_idle", bus.req == '0 && !bus.busy && !bus.sd_read_done, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n0, h0;
    bus.init_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_done", bus.req_done, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sd_addr", bus.sd_addr, 0);
    chk("rst_start", bus.sd_read_start, 0);
    chk("rst_rd_error", bus.rd_error, 0);
    reset = 1'b0;
    fix_addr[0] = 32'h10;
    fix_addr[1] = 32'h20;
    en_mask = 2'b01;
    repeat (50) begin @(negedge clk); chk("start_before_init", bus.sd_read_start, 0); end
    bus.init_done = 1'b1;
    @(negedge clk) chk("start_lat1", bus.sd_read_start, 0);
    @(negedge clk) chk("start_lat2", bus.sd_read_start, 0);
    @(negedge clk) chk("start_lat3", bus.sd_read_start, 1);
    chk("first_addr", bus.sd_addr, 32'h10);
    en_mask = '0;
    wait_dones(1);
    wait_idle();
    chk("rd_data_hold", bus.rd_data, 32'hDEADBEEF);
    fix_addr[0] = 32'h100;
    fix_addr[1] = 32'h200;
    gseq.delete();
    gaddr.delete();
    ctl_lat = 0;
    ctl_rand = 1;
    en_mask = 2'b11;
    wait_dones(4);
    en_mask = '0;
    wait_idle();
    chk("rr_count", gseq.size() >= 4, 1);
    if (gseq.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        if (k > 0) chk("rr_alternate", gseq[k] != gseq[k-1], 1);
        chk("rr_addr", gaddr[k], 32'h100 * (gseq[k] + 1));
      end
    ctl_hold = 5;
    ctl_lat = 3;
    h0 = hold_seen;
    en_mask = 2'b01;
    wait_start();
    en_mask = '0;
    wait_dones(1);
    wait_idle();
    chk("hold_cycles", hold_seen - h0, 5);
    ctl_hold = 0;
    ctl_lat = 1000;
    en_mask = 2'b01;
    wait_start();
    en_mask = '0;
    repeat (5) @(negedge clk);
    n0 = ndone;
    bus.init_done = 1'b0;
    @(negedge clk);
    chk("abort_start", bus.sd_read_start, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (10) begin @(negedge clk); chk("abort_idle", bus.sd_read_start, 0); end
    chk("abort_no_done", ndone, n0);
    ctl_lat = 10;
    bus.init_done = 1'b1;
    wait_dones(1);
    wait_idle();
    chk("abort_resume_id", gseq[$], 0);
`ifdef SD_ARB_TIMEOUT_EN
    ctl_mute = 1;
    en_mask = 2'b01;
    wait_start();
    en_mask = '0;
    wait_dones(1);
    ctl_mute = 0;
    wait_idle();
    en_mask = 2'b10;
    wait_start();
    en_mask = '0;
    wait_dones(1);
    wait_idle();
`endif
    rand_mode = 1;
    ctl_lat = 0;
    ctl_hold = -1;
    en_mask = 2'b11;
    wait_dones(40);
    en_mask = '0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares the single-block SD read path of the SD card controller between NUM_REQ independent requesters, for example a sprite/tile loader and an audio streamer.
- Waits for SD initialisation, selects one requester round-robin, and drives the controller's address and read_start level.
- Holds read_start until the controller's read_done, captures the 32-bit response data, then releases the handshake before the next grant.
- Sits between the user-logic clients and the SD controller, in the SD clock domain.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- ADDR_W, 32: block address width presented to the SD controller.
- TIMEOUT_CYCLES, 4096: watchdog limit in clk cycles. Used only when the optional feature is enabled.

Ports:
- clk  in  1  SD clock; the same clock drives the SD controller.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request level; held until the matching req_done.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_done  out  NUM_REQ  one-cycle pulse to the granted requester when rd_data is valid.
- rd_data  out  32  captured response data; holds its value until the next capture.
- grant_id  out  2  index of the current or last granted requester.
- busy  out  1  high from grant until the end of RELEASE.
- init_done  in  1  SD controller initialisation complete (level).
- sd_addr  out  ADDR_W  address to the SD controller.
- sd_read_start  out  1  read request level to the SD controller.
- sd_read_done  in  1  SD controller read complete; stays high until read_start drops.
- sd_response_data  in  32  SD controller response data.
- rd_error  out  1  pulse on watchdog abort (feature-gated; tied to 0 otherwise).

Behaviour:
- Reset (asynchronous, active-high) values:
  - state = WAIT_INIT; rr_ptr = NUM_REQ-1.
  - All outputs 0: req_done, rd_data, grant_id, busy, sd_addr, sd_read_start, rd_error.
  - Watchdog counter = 0.
- Registered-output FSM with states WAIT_INIT, ARB, ISSUE, WAIT_DONE, RELEASE.
- WAIT_INIT:
  - Stay while init_done = 0; go to ARB when init_done = 1.
  - Requests arriving earlier are held off, not dropped.
- ARB:
  - If no req bit is set, stay.
  - Otherwise pick the first set bit searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Latch the winner into grant_id and rr_ptr, latch sd_addr = req_addr[winner], set busy = 1, go to ISSUE.
  - Exactly one winner per decision. A requester that is the only one asserting req can win on consecutive rounds.
- ISSUE:
  - sd_read_start = 1, go to WAIT_DONE.
  - Latency: sd_read_start rises 2 cycles after req is seen in ARB.
- WAIT_DONE:
  - Hold sd_read_start = 1 and sd_addr stable until sd_read_done = 1.
  - On that cycle: rd_data <= sd_response_data, pulse req_done[grant_id] for exactly 1 cycle, sd_read_start <= 0, go to RELEASE.
- RELEASE:
  - Wait for sd_read_done = 0 (the controller returns to idle), then set busy = 0 and go to ARB.
  - No new grant may issue while sd_read_done is still high.
- Requester rules:
  - A requester deasserting req after being granted does not cancel the transaction; req_done still pulses.
  - A requester must drop req within 1 cycle of req_done, otherwise it is treated as a new request at its next round-robin turn.
- init_done falling in any state other than WAIT_INIT is a controller reset. Required response:
  - Drop sd_read_start and busy, no req_done pulse.
  - Return to WAIT_INIT; rr_ptr is preserved.
- Reset asserted mid-transaction: immediate return to reset values. The SD controller is reset by the same signal.
- Simultaneous requests: strictly round-robin. With all NUM_REQ requesters asserting continuously, each is served once per NUM_REQ transactions.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle spent there.
  - If it reaches TIMEOUT_CYCLES without sd_read_done: drop sd_read_start, pulse rd_error for 1 cycle, pulse req_done[grant_id] with rd_data unchanged, go to RELEASE.
- When undefined: no counter logic; rd_error is driven constant 0; WAIT_DONE waits indefinitely.

Test Plan:
- init_done = 0 with req = 2'b01 for 50 cycles -> sd_read_start stays 0. Raise init_done -> sd_read_start = 1 two cycles after ARB, sd_addr = req_addr[0].
- req0 addr 0x00000010; controller model returns read_done after 20 cycles with data 0xDEADBEEF -> rd_data = 0xDEADBEEF, req_done = 2'b01 for exactly 1 cycle, sd_read_start falls the same cycle.
- req = 2'b11 held, 4 transactions -> grant_id sequence 0,1,0,1. sd_addr alternates 0x100/0x200 matching req_addr.
- Controller model holds read_done high 5 cycles after read_start drops -> busy stays 1 and no new sd_read_start until read_done is low.
- init_done dropped during WAIT_DONE -> sd_read_start = 0 next cycle, no req_done pulse, state returns to WAIT_INIT. Restore init_done -> the same requester's pending request completes.
- SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 64, no read_done -> rd_error pulses at cycle 64 of WAIT_DONE, req_done pulses, busy clears, next request is served.
